// File: rtl/irr_priority_resolver.sv
// 8259 IRR capture, OCW1 masking and rotating-priority resolution with in-service blocking.
// Optional macro IRR_INPUT_SYNC_EN adds a 2-flop synchronizer on ir_in.
module irr_priority_resolver #(
  parameter int unsigned NUM_IR     = 8,
  parameter logic [7:0]  RESET_MASK = 8'hFF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IR-1:0]           ir_in,
  input  logic                        level_edge_triggered,
  input  logic [NUM_IR-1:0]           int_mask,
  input  logic [NUM_IR-1:0]           clear_IRR,
  input  logic [$clog2(NUM_IR)-1:0]   priority_rotate,
  input  logic [NUM_IR-1:0]           in_service_reg,
  input  logic                        freeze,
  output logic [NUM_IR-1:0]           interrupt_request_reg,
  output logic [NUM_IR-1:0]           interrupt,
  output logic                        int_pending
);

  localparam int unsigned IDX_W = $clog2(NUM_IR);
  localparam logic [NUM_IR-1:0] ALL_ONES = '1;

  // Only the 8-line 8259 arrangement is meaningful.
  if (NUM_IR != 8 || $bits(RESET_MASK) != NUM_IR) begin : g_bad_cfg
    $error("irr_priority_resolver supports NUM_IR = 8 only");
  end

  logic [NUM_IR-1:0] ir_s;
  logic [NUM_IR-1:0] ir_prev;
  logic [NUM_IR-1:0] irr_next;
  logic [NUM_IR-1:0] masked;
  logic [NUM_IR-1:0] next_interrupt;

`ifdef IRR_INPUT_SYNC_EN
  logic [NUM_IR-1:0] sync_q1;
  logic [NUM_IR-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= ir_in;
      sync_q2 <= sync_q1;
    end
  end

  assign ir_s = sync_q2;
`else
  assign ir_s = ir_in;
`endif

  // Clear always wins over a same-cycle set.
  always_comb begin
    irr_next = '0;
    if (level_edge_triggered) begin
      irr_next = ir_s & ~clear_IRR;
    end else begin
      irr_next = (interrupt_request_reg | (ir_s & ~ir_prev)) & ~clear_IRR;
    end
  end

  // A full clear (ICW1) forces the edge history high so lines already up are not seen as edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      interrupt_request_reg <= '0;
      ir_prev               <= ALL_ONES;
    end else begin
      interrupt_request_reg <= irr_next;
      ir_prev               <= (clear_IRR == ALL_ONES) ? ALL_ONES : ir_s;
    end
  end

  assign masked = interrupt_request_reg & ~int_mask;

  // Scan from the highest-priority position; rank is distance from it.
  always_comb begin : resolve
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] pos;
    logic             req_found;
    logic [IDX_W-1:0] req_rank;
    logic [IDX_W-1:0] req_idx;
    logic             isr_found;
    logic [IDX_W-1:0] isr_rank;
    base           = priority_rotate + IDX_W'(1);
    pos            = '0;
    req_found      = 1'b0;
    req_rank       = '0;
    req_idx        = '0;
    isr_found      = 1'b0;
    isr_rank       = '0;
    next_interrupt = '0;
    for (int unsigned k = 0; k < NUM_IR; k++) begin
      pos = base + IDX_W'(k);
      if (!req_found && masked[pos]) begin
        req_found = 1'b1;
        req_rank  = IDX_W'(k);
        req_idx   = pos;
      end
      if (!isr_found && in_service_reg[pos]) begin
        isr_found = 1'b1;
        isr_rank  = IDX_W'(k);
      end
    end
    if (req_found && (!isr_found || (req_rank < isr_rank))) begin
      next_interrupt[req_idx] = 1'b1;
    end
  end

  // Output stage holds during the INTA sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      interrupt   <= '0;
      int_pending <= 1'b0;
    end else if (!freeze) begin
      interrupt   <= next_interrupt;
      int_pending <= |next_interrupt;
    end
  end

endmodule

// File: tb/tb_irr_priority_resolver.sv
// Scoreboard bench for irr_priority_resolver: directed stimulus pushes timed expectations,
// an independent monitor compares them against the DUT after each rising edge.
module tb_irr_priority_resolver;

`ifdef IRR_INPUT_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir_in;
  logic       level_edge_triggered;
  logic [7:0] int_mask;
  logic [7:0] clear_IRR;
  logic [2:0] priority_rotate;
  logic [7:0] in_service_reg;
  logic       freeze;
  logic [7:0] interrupt_request_reg;
  logic [7:0] interrupt;
  logic       int_pending;

  irr_priority_resolver dut (
    .clk                   (clk),
    .reset                 (reset),
    .ir_in                 (ir_in),
    .level_edge_triggered  (level_edge_triggered),
    .int_mask              (int_mask),
    .clear_IRR             (clear_IRR),
    .priority_rotate       (priority_rotate),
    .in_service_reg        (in_service_reg),
    .freeze                (freeze),
    .interrupt_request_reg (interrupt_request_reg),
    .interrupt             (interrupt),
    .int_pending           (int_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    string      nm;
    bit         ci;
    logic [7:0] irr;
    bit         cn;
    logic [7:0] intr;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  // Monitor: after every rising edge, check every expectation due on this cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at < cyc) begin
          n_bad++;
          $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", sb[i].nm, sb[i].at, cyc);
          sb.delete(i);
        end else if (sb[i].at == cyc) begin
          if (sb[i].ci) begin
            n_vec++;
            if (interrupt_request_reg !== sb[i].irr) begin
              n_bad++;
              $display("FAIL %s irr: got %h want %h", sb[i].nm, interrupt_request_reg, sb[i].irr);
            end
          end
          if (sb[i].cn) begin
            n_vec++;
            if (interrupt !== sb[i].intr) begin
              n_bad++;
              $display("FAIL %s interrupt: got %h want %h", sb[i].nm, interrupt, sb[i].intr);
            end
            n_vec++;
            if (int_pending !== (|sb[i].intr)) begin
              n_bad++;
              $display("FAIL %s int_pending: got %b want %b", sb[i].nm, int_pending, |sb[i].intr);
            end
          end
          sb.delete(i);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_at(input int d, input string nm, input bit ci, input logic [7:0] irr,
                           input bit cn, input logic [7:0] intr);
    exp_t e;
    e.at = cyc + d; e.nm = nm; e.ci = ci; e.irr = irr; e.cn = cn; e.intr = intr;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1; ir_in = '0; level_edge_triggered = 1'b0; int_mask = '0; clear_IRR = '0;
    priority_rotate = 3'd7; in_service_reg = '0; freeze = 1'b0;
    expect_at(1, "reset", 1, 8'h00, 1, 8'h00);
    tick(); tick();
    reset = 1'b0;
    expect_at(1, "idle", 1, 8'h00, 1, 8'h00);
    tick();

    // Edge capture and latency on IR3, then clear while held high.
    ir_in = 8'h08;
    expect_at(1 + L, "t1_irr", 1, 8'h08, 1, 8'h00);
    expect_at(2 + L, "t1_int", 1, 8'h08, 1, 8'h08);
    repeat (2 + L) tick();
    clear_IRR = 8'h08;
    expect_at(1, "t1_clr", 1, 8'h00, 1, 8'h08);
    expect_at(2, "t1_hold", 1, 8'h00, 1, 8'h00);
    tick(); clear_IRR = '0; tick();
    ir_in = '0;
    repeat (2 + L) tick();

    // Rotation and mask on IRR=81.
    ir_in = 8'h81;
    expect_at(1 + L, "t2_irr", 1, 8'h81, 0, 8'h00);
    expect_at(2 + L, "t2_rot7", 1, 8'h81, 1, 8'h01);
    repeat (2 + L) tick();
    priority_rotate = 3'd0;
    expect_at(1, "t2_rot0", 0, 8'h00, 1, 8'h80);
    tick();
    priority_rotate = 3'd7; int_mask = 8'h01;
    expect_at(1, "t2_mask", 0, 8'h00, 1, 8'h80);
    tick();
    int_mask = 8'hFF;
    expect_at(1, "t2_mask_all", 1, 8'h81, 1, 8'h00);
    tick();
    int_mask = 8'h00; clear_IRR = 8'h81;
    expect_at(1, "t2_clr", 1, 8'h00, 1, 8'h01);
    tick(); clear_IRR = '0; ir_in = '0;
    repeat (2 + L) tick();

    // In-service blocking.
    in_service_reg = 8'h04; ir_in = 8'h14;
    expect_at(1 + L, "t3_irr", 1, 8'h14, 0, 8'h00);
    expect_at(2 + L, "t3_block", 1, 8'h14, 1, 8'h00);
    repeat (2 + L) tick();
    in_service_reg = 8'h10;
    expect_at(1, "t3_nest", 0, 8'h00, 1, 8'h04);
    tick();
    priority_rotate = 3'd3;
    expect_at(1, "t3_rot3_block", 0, 8'h00, 1, 8'h00);
    tick();
    in_service_reg = 8'h00;
    expect_at(1, "t3_rot3_free", 0, 8'h00, 1, 8'h10);
    tick();
    priority_rotate = 3'd7; clear_IRR = 8'h14; ir_in = '0;
    tick(); clear_IRR = '0;
    repeat (2 + L) tick();

    // Edge mode: held line does not re-arm after clear.
    ir_in = 8'h20;
    expect_at(1 + L, "t4_set", 1, 8'h20, 0, 8'h00);
    repeat (2 + L) tick();
    clear_IRR = 8'h20;
    expect_at(1, "t4_clr", 1, 8'h00, 0, 8'h00);
    expect_at(2, "t4_stay", 1, 8'h00, 1, 8'h00);
    tick(); clear_IRR = '0; tick(); tick();
    ir_in = '0;
    expect_at(1 + L, "t4_low", 1, 8'h00, 0, 8'h00);
    repeat (2 + L) tick();
    ir_in = 8'h20;
    expect_at(1 + L, "t4_rearm", 1, 8'h20, 0, 8'h00);
    repeat (2 + L) tick();
    clear_IRR = 8'h20; ir_in = '0;
    tick(); clear_IRR = '0;
    repeat (2 + L) tick();

    // Level mode: clear suppresses the bit for one cycle only.
    level_edge_triggered = 1'b1;
    tick();
    ir_in = 8'h20;
    expect_at(1 + L, "t4l_set", 1, 8'h20, 0, 8'h00);
    repeat (2 + L) tick();
    clear_IRR = 8'h20;
    expect_at(1, "t4l_clr", 1, 8'h00, 0, 8'h00);
    expect_at(2, "t4l_back", 1, 8'h20, 0, 8'h00);
    tick(); clear_IRR = '0; tick();
    ir_in = '0;
    expect_at(1 + L, "t4l_fall", 1, 8'h00, 0, 8'h00);
    repeat (2 + L) tick();
    level_edge_triggered = 1'b0;
    tick();

    // Freeze holds the output while IRR keeps capturing.
    ir_in = 8'h02;
    expect_at(1 + L, "t5_set", 1, 8'h02, 0, 8'h00);
    expect_at(2 + L, "t5_int", 1, 8'h02, 1, 8'h02);
    repeat (2 + L) tick();
    freeze = 1'b1;
    tick();
    ir_in = 8'h03;
    expect_at(1 + L, "t5_irr", 1, 8'h03, 1, 8'h02);
    expect_at(2 + L, "t5_held", 1, 8'h03, 1, 8'h02);
    repeat (2 + L) tick();
    freeze = 1'b0;
    expect_at(1, "t5_release", 0, 8'h00, 1, 8'h01);
    tick();
`ifndef IRR_INPUT_SYNC_EN
    // Full clear forces edge history high: a line rising right after it is not an edge.
    clear_IRR = 8'hFF; ir_in = '0;
    expect_at(1, "t5_icw1", 1, 8'h00, 0, 8'h00);
    tick();
    clear_IRR = '0; ir_in = 8'h04;
    expect_at(1, "t5_noedge", 1, 8'h00, 1, 8'h00);
    tick();
    ir_in = '0;
    tick();
    ir_in = 8'h04;
    expect_at(1, "t5_edge", 1, 8'h04, 0, 8'h00);
    tick();
    clear_IRR = 8'h04; ir_in = '0;
    tick(); clear_IRR = '0; tick(); tick();
`else
    clear_IRR = 8'h03; ir_in = '0;
    tick(); clear_IRR = '0;
    repeat (4) tick();
`endif

    // Reset while frozen with all requests pending.
    ir_in = 8'hFF;
    expect_at(1 + L, "t6_irr", 1, 8'hFF, 0, 8'h00);
    expect_at(2 + L, "t6_int", 1, 8'hFF, 1, 8'h01);
    repeat (2 + L) tick();
    freeze = 1'b1;
    tick();
    reset = 1'b1;
    expect_at(1, "t6_rst", 1, 8'h00, 1, 8'h00);
    tick();
    reset = 1'b0; freeze = 1'b0;
    expect_at(1, "t6_after", 1, 8'h00, 1, 8'h00);
    tick();
    ir_in = '0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
